mm_job_sequencer: RTL and testbench

- Front-end controller for the matrix_multiplier datapath.
- Accepts matrix-multiply jobs into a small command queue and programs the multiplier's dimension inputs for each job.
- Launches each job, waits for completion, then relocates the multiplier's zero-based RAM addresses by per-job base offsets.
- Arbitrates the X/Y/Z RAM ports between the host (when idle) and the multiplier (when running), and reports status, cycle counts and errors.

---
 rtl/mm_seq_pkg.sv | 28 ++
 rtl/mm_job_sequencer_if.sv | 25 ++
 rtl/mm_cmd_fifo.sv | 49 ++++
 rtl/mm_job_sequencer.sv | 168 ++++++++++++++++
 tb/tb_mm_job_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mm_seq_pkg.sv
// Shared types for the matrix-multiplier job sequencer: FSM encoding,
// queued command record and host RAM-select codes.
package mm_seq_pkg;

    localparam int MM_ADDR_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_ISSUE = 2'd2,
        ST_RUN   = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [MM_ADDR_WIDTH-1:0] x_rows;
        logic [MM_ADDR_WIDTH-1:0] y_cols;
        logic [MM_ADDR_WIDTH-1:0] inner;
        logic [MM_ADDR_WIDTH-1:0] x_base;
        logic [MM_ADDR_WIDTH-1:0] y_base;
        logic [MM_ADDR_WIDTH-1:0] z_base;
    } mm_cmd_t;

    localparam logic [1:0] HOST_SEL_X    = 2'd0;
    localparam logic [1:0] HOST_SEL_Y    = 2'd1;
    localparam logic [1:0] HOST_SEL_Z    = 2'd2;
    localparam logic [1:0] HOST_SEL_NONE = 2'd3;

endpackage

// File: rtl/mm_job_sequencer_if.sv
// Job command handshake between a host and the sequencer's command queue.
interface mm_job_sequencer_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_x_rows;
    logic [ADDR_WIDTH-1:0] cmd_y_cols;
    logic [ADDR_WIDTH-1:0] cmd_inner;
    logic [ADDR_WIDTH-1:0] cmd_x_base;
    logic [ADDR_WIDTH-1:0] cmd_y_base;
    logic [ADDR_WIDTH-1:0] cmd_z_base;

    modport master (
        output cmd_valid, cmd_x_rows, cmd_y_cols, cmd_inner,
               cmd_x_base, cmd_y_base, cmd_z_base,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_x_rows, cmd_y_cols, cmd_inner,
               cmd_x_base, cmd_y_base, cmd_z_base,
        output cmd_ready
    );
endinterface

// File: rtl/mm_cmd_fifo.sv
// Show-ahead command queue; extra pointer bit distinguishes full from empty.
module mm_cmd_fifo
    import mm_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    flush,
    input  logic    push,
    input  mm_cmd_t din,
    input  logic    pop,
    output mm_cmd_t dout,
    output logic    full,
    output logic    empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    mm_cmd_t       mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A full queue can still take a write in the cycle its head leaves.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/mm_job_sequencer.sv
// Queues matrix-multiply jobs, launches them on the multiplier, relocates its
// RAM addresses by per-job bases and hands the RAMs to the host when idle.
//
// state | meaning
// IDLE  | waiting for a queued job; host owns RAMs when queue is empty
// CHECK | popped job held; reject it if any dimension is zero
// ISSUE | one-cycle mm_start, cycle counter restarts at 1
// RUN   | counting until mm_busy drops (ignored on the first RUN cycle)
module mm_job_sequencer
    import mm_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = MM_ADDR_WIDTH,
    parameter int DATA_WIDTH = 32,
    parameter int CMD_DEPTH  = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mm_job_sequencer_if.slave     cmd_bus,
    input  logic                  abort,
    input  logic                  err_clr,
    output logic                  mm_start,
    output logic                  mm_rst,
    input  logic                  mm_busy,
    output logic [ADDR_WIDTH-1:0] mm_x_rows,
    output logic [ADDR_WIDTH-1:0] mm_y_cols,
    output logic [ADDR_WIDTH-1:0] mm_x_cols_y_rows,
    input  logic [ADDR_WIDTH-1:0] mm_x_addr,
    input  logic [ADDR_WIDTH-1:0] mm_y_addr,
    input  logic [ADDR_WIDTH-1:0] mm_z_addr,
    input  logic [DATA_WIDTH-1:0] mm_z_data,
    input  logic                  mm_z_wen,
    input  logic [1:0]            host_sel,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    input  logic                  host_wen,
    output logic                  host_grant,
    output logic [ADDR_WIDTH-1:0] x_ram_addr,
    output logic [ADDR_WIDTH-1:0] y_ram_addr,
    output logic [ADDR_WIDTH-1:0] z_ram_addr,
    output logic                  x_ram_wen,
    output logic                  y_ram_wen,
    output logic                  z_ram_wen,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  busy,
    output logic                  job_done,
    output logic [CNT_WIDTH-1:0]  jobs_completed,
    output logic [CNT_WIDTH-1:0]  last_cycles,
    output logic                  err_zero_dim
);
    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] CHECK = ST_CHECK;
    localparam logic [1:0] ISSUE = ST_ISSUE;
    localparam logic [1:0] RUN   = ST_RUN;

    logic [1:0]     state;
    mm_cmd_t        job;
    mm_cmd_t        cmd_in;
    mm_cmd_t        head;
    logic           fifo_full;
    logic           fifo_empty;
    logic           push;
    logic           pop;
    logic           zero_dim;
    logic           run_first;
    logic [CNT_WIDTH-1:0] cyc_cnt;

    assign cmd_in = '{x_rows: cmd_bus.cmd_x_rows, y_cols: cmd_bus.cmd_y_cols,
                      inner:  cmd_bus.cmd_inner,  x_base: cmd_bus.cmd_x_base,
                      y_base: cmd_bus.cmd_y_base, z_base: cmd_bus.cmd_z_base};

    assign cmd_bus.cmd_ready = !fifo_full;
    assign push = cmd_bus.cmd_valid && !fifo_full && !abort;
    assign pop  = (state == IDLE) && !fifo_empty && !abort;

    mm_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (abort),
        .push  (push),
        .din   (cmd_in),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign zero_dim         = (job.x_rows == '0) || (job.y_cols == '0) || (job.inner == '0);
    assign mm_start         = (state == ISSUE);
    assign mm_x_rows        = job.x_rows;
    assign mm_y_cols        = job.y_cols;
    assign mm_x_cols_y_rows = job.inner;
    assign host_grant       = (state == IDLE) && fifo_empty;
    assign busy             = (state != IDLE) || !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            job            <= '0;
            cyc_cnt        <= '0;
            run_first      <= 1'b0;
            mm_rst         <= 1'b1;
            job_done       <= 1'b0;
            jobs_completed <= '0;
            last_cycles    <= '0;
            err_zero_dim   <= 1'b0;
        end else begin
            mm_rst   <= abort;
            job_done <= 1'b0;
            if (err_clr) err_zero_dim <= 1'b0;
            if (abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (pop) begin
                        job   <= head;
                        state <= CHECK;
                    end
                    CHECK: if (zero_dim) begin
                        err_zero_dim <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        state <= ISSUE;
                    end
                    ISSUE: begin
                        cyc_cnt   <= CNT_WIDTH'(1);
                        run_first <= 1'b1;
                        state     <= RUN;
                    end
                    RUN: begin
                        cyc_cnt   <= cyc_cnt + CNT_WIDTH'(1);
                        run_first <= 1'b0;
                        if (!run_first && !mm_busy) begin
                            last_cycles    <= cyc_cnt;
                            jobs_completed <= jobs_completed + CNT_WIDTH'(1);
                            job_done       <= 1'b1;
                            state          <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        x_ram_addr = mm_x_addr + job.x_base;
        y_ram_addr = mm_y_addr + job.y_base;
        z_ram_addr = mm_z_addr + job.z_base;
        x_ram_wen  = 1'b0;
        y_ram_wen  = 1'b0;
        z_ram_wen  = mm_z_wen;
        ram_wdata  = mm_z_data;
        if (host_grant) begin
            x_ram_addr = host_addr;
            y_ram_addr = host_addr;
            z_ram_addr = host_addr;
            z_ram_wen  = 1'b0;
            ram_wdata  = host_wdata;
            case (host_sel)
                HOST_SEL_X:    x_ram_wen = host_wen;
                HOST_SEL_Y:    y_ram_wen = host_wen;
                HOST_SEL_Z:    z_ram_wen = host_wen;
                HOST_SEL_NONE: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mm_job_sequencer.sv
// Bench for mm_job_sequencer: multiplier model with programmable busy length,
// directed corner cases, host-port vector table and a randomized job stream.
module tb_mm_job_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        abort, err_clr, mm_busy;
    logic [31:0] mm_x_addr, mm_y_addr, mm_z_addr, mm_z_data;
    logic        mm_z_wen;
    logic [1:0]  host_sel;
    logic [31:0] host_addr, host_wdata;
    logic        host_wen;
    logic        mm_start, mm_rst, host_grant, busy, job_done, err_zero_dim;
    logic [31:0] mm_x_rows, mm_y_cols, mm_x_cols_y_rows;
    logic [31:0] x_ram_addr, y_ram_addr, z_ram_addr, ram_wdata;
    logic        x_ram_wen, y_ram_wen, z_ram_wen;
    logic [31:0] jobs_completed, last_cycles;

    mm_job_sequencer_if #(.ADDR_WIDTH(32)) cmd_bus ();

    mm_job_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cmd_bus(cmd_bus), .abort(abort), .err_clr(err_clr),
        .mm_start(mm_start), .mm_rst(mm_rst), .mm_busy(mm_busy),
        .mm_x_rows(mm_x_rows), .mm_y_cols(mm_y_cols), .mm_x_cols_y_rows(mm_x_cols_y_rows),
        .mm_x_addr(mm_x_addr), .mm_y_addr(mm_y_addr), .mm_z_addr(mm_z_addr),
        .mm_z_data(mm_z_data), .mm_z_wen(mm_z_wen),
        .host_sel(host_sel), .host_addr(host_addr), .host_wdata(host_wdata), .host_wen(host_wen),
        .host_grant(host_grant), .x_ram_addr(x_ram_addr), .y_ram_addr(y_ram_addr),
        .z_ram_addr(z_ram_addr), .x_ram_wen(x_ram_wen), .y_ram_wen(y_ram_wen),
        .z_ram_wen(z_ram_wen), .ram_wdata(ram_wdata), .busy(busy), .job_done(job_done),
        .jobs_completed(jobs_completed), .last_cycles(last_cycles), .err_zero_dim(err_zero_dim)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Multiplier model: after a start it reports busy for exactly b RUN cycles.
    int          b_next = 1;
    bit          rand_mode = 1'b0;
    int          rem = 0;
    int          n_start = 0;
    int          n_done = 0;
    logic [95:0] start_log[$];
    int          b_log[$];
    logic [31:0] done_lc[$];

    always @(negedge clk) begin
        int b;
        if (!rst_n || mm_rst) begin
            rem     = 0;
            mm_busy = 1'b0;
        end else if (mm_start) begin
            b = rand_mode ? int'($urandom_range(0, 5)) : b_next;
            n_start++;
            start_log.push_back({mm_x_rows, mm_y_cols, mm_x_cols_y_rows});
            b_log.push_back(b);
            rem = b;
        end else begin
            mm_busy = (rem > 0);
            if (rem > 0) rem--;
        end
        if (job_done) begin
            n_done++;
            done_lc.push_back(last_cycles);
        end
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        start_log.delete();
        b_log.delete();
        done_lc.delete();
    endtask

    task automatic enq(input logic [31:0] xr, yc, inr, xb, yb, zb);
        bit ok = 1'b0;
        cmd_bus.cmd_x_rows = xr;
        cmd_bus.cmd_y_cols = yc;
        cmd_bus.cmd_inner  = inr;
        cmd_bus.cmd_x_base = xb;
        cmd_bus.cmd_y_base = yb;
        cmd_bus.cmd_z_base = zb;
        cmd_bus.cmd_valid  = 1'b1;
        for (int i = 0; i < 500 && !ok; i++) begin
            #1;
            ok = cmd_bus.cmd_ready;
            tick();
        end
        cmd_bus.cmd_valid = 1'b0;
        if (!ok) check("enq_timeout", 96'(ok), 96'(1));
    endtask

    task automatic wait_start(input int target, input int budget);
        for (int i = 0; i < budget && n_start < target; i++) tick();
        check("wait_start", 96'(n_start), 96'(target));
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget && n_done < target; i++) tick();
        check("wait_done", 96'(n_done), 96'(target));
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] addr;
        logic [31:0] data;
        logic        wen;
        logic [2:0]  exp_wen;
    } host_vec_t;

    host_vec_t vecs[7];

    initial begin
        int s0, d0;
        logic [31:0] jc0;
        int nvalid;
        bit any_zero;
        logic [95:0] exp_dims[$];
        logic [31:0] xr, yc, inr;

        vecs[0] = '{2'd0, 32'h0000_0007, 32'h0000_1111, 1'b1, 3'b100};
        vecs[1] = '{2'd1, 32'h0000_0007, 32'h0000_ABCD, 1'b1, 3'b010};
        vecs[2] = '{2'd2, 32'h0000_0100, 32'h1234_5678, 1'b1, 3'b001};
        vecs[3] = '{2'd3, 32'h0000_0033, 32'h0000_00FF, 1'b1, 3'b000};
        vecs[4] = '{2'd1, 32'h0000_0008, 32'hDEAD_BEEF, 1'b0, 3'b000};
        vecs[5] = '{2'd2, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1, 3'b001};
        vecs[6] = '{2'd0, 32'h0000_0000, 32'h0000_0000, 1'b0, 3'b000};

        rst_n = 1'b0; abort = 1'b0; err_clr = 1'b0; mm_busy = 1'b0;
        mm_x_addr = '0; mm_y_addr = '0; mm_z_addr = '0; mm_z_data = '0; mm_z_wen = 1'b0;
        host_sel = 2'd3; host_addr = '0; host_wdata = '0; host_wen = 1'b0;
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_x_rows = '0; cmd_bus.cmd_y_cols = '0; cmd_bus.cmd_inner = '0;
        cmd_bus.cmd_x_base = '0; cmd_bus.cmd_y_base = '0; cmd_bus.cmd_z_base = '0;

        // Reset values
        tick(); tick();
        #1;
        check("rst_cmd_ready", 96'(cmd_bus.cmd_ready), 96'(1));
        check("rst_host_grant", 96'(host_grant), 96'(1));
        check("rst_mm_rst", 96'(mm_rst), 96'(1));
        check("rst_outs", 96'({busy, job_done, mm_start, err_zero_dim, jobs_completed, last_cycles}), 96'(0));
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_release_mm_rst_held", 96'(mm_rst), 96'(1));
        tick();
        check("rst_release_mm_rst_low", 96'(mm_rst), 96'(0));

        // Single 2x3x2 job, busy 50 cycles
        clear_logs();
        s0 = n_start; d0 = n_done;
        b_next = 50;
        enq(32'd2, 32'd2, 32'd3, 32'h10, 32'h20, 32'h40);
        wait_start(s0 + 1, 20);
        mm_x_addr = 32'd5; mm_y_addr = 32'd6; mm_z_addr = 32'd7;
        mm_z_data = 32'hCAFE_0001; mm_z_wen = 1'b1;
        host_sel = 2'd1; host_addr = 32'd7; host_wdata = 32'hABCD; host_wen = 1'b1;
        #1;
        check("run_dims", {mm_x_rows, mm_y_cols, mm_x_cols_y_rows}, {32'd2, 32'd2, 32'd3});
        check("run_addrs", {x_ram_addr, y_ram_addr, z_ram_addr}, {32'h15, 32'h26, 32'h47});
        check("run_wen", 96'({x_ram_wen, y_ram_wen, z_ram_wen}), 96'(3'b001));
        check("run_wdata", 96'(ram_wdata), 96'(32'hCAFE_0001));
        check("run_grant_busy", 96'({host_grant, busy}), 96'(2'b01));
        mm_z_addr = 32'hFFFF_FFF0;
        #1;
        check("run_z_wrap", 96'(z_ram_addr), 96'(32'h30));
        mm_z_wen = 1'b0; host_wen = 1'b0;
        wait_done(d0 + 1, 200);
        check("single_starts", 96'(n_start - s0), 96'(1));
        check("single_jobs_completed", 96'(jobs_completed), 96'(1));
        check("single_last_cycles", 96'(last_cycles), 96'(51));
        check("single_grant_after", 96'(host_grant), 96'(1));
        tick();
        check("single_done_count", 96'(n_done - d0), 96'(1));

        // Host-port vector table while idle
        foreach (vecs[i]) begin
            host_sel = vecs[i].sel; host_addr = vecs[i].addr;
            host_wdata = vecs[i].data; host_wen = vecs[i].wen;
            #1;
            check("host_wen", 96'({x_ram_wen, y_ram_wen, z_ram_wen}), 96'(vecs[i].exp_wen));
            check("host_addr", {x_ram_addr, y_ram_addr, z_ram_addr}, {vecs[i].addr, vecs[i].addr, vecs[i].addr});
            check("host_wdata", 96'(ram_wdata), 96'(vecs[i].data));
            tick();
        end
        host_wen = 1'b0; host_sel = 2'd3;

        // Five jobs into a four-deep queue
        clear_logs();
        s0 = n_start; d0 = n_done; jc0 = jobs_completed;
        b_next = 30;
        for (int i = 0; i < 5; i++)
            enq(32'(i + 1), 32'(i + 2), 32'(i + 3), 32'h0, 32'h0, 32'h0);
        #1;
        check("full_cmd_ready", 96'(cmd_bus.cmd_ready), 96'(0));
        check("full_grant_busy", 96'({host_grant, busy}), 96'(2'b01));
        wait_done(d0 + 4, 400);
        check("four_done_grant", 96'(host_grant), 96'(0));
        wait_done(d0 + 5, 100);
        check("five_done_grant", 96'(host_grant), 96'(1));
        check("five_jobs_completed", 96'(jobs_completed), 96'(jc0 + 5));
        check("five_starts", 96'(n_start - s0), 96'(5));
        for (int i = 0; i < 5; i++)
            if (i < start_log.size())
                check("five_order", start_log[i], {32'(i + 1), 32'(i + 2), 32'(i + 3)});
        for (int i = 0; i < 5; i++)
            if (i < done_lc.size())
                check("five_last_cycles", 96'(done_lc[i]), 96'(31));

        // Zero-dimension job followed by a valid one
        clear_logs();
        s0 = n_start; d0 = n_done; jc0 = jobs_completed;
        b_next = 3;
        enq(32'd2, 32'd0, 32'd2, 32'h0, 32'h0, 32'h0);
        enq(32'd1, 32'd1, 32'd1, 32'h0, 32'h0, 32'h0);
        wait_done(d0 + 1, 100);
        check("zero_err_set", 96'(err_zero_dim), 96'(1));
        check("zero_starts", 96'(n_start - s0), 96'(1));
        if (start_log.size() > 0)
            check("zero_second_dims", start_log[0], {32'd1, 32'd1, 32'd1});
        check("zero_jobs_completed", 96'(jobs_completed), 96'(jc0 + 1));
        check("zero_last_cycles", 96'(last_cycles), 96'(4));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        #1;
        check("err_clr", 96'(err_zero_dim), 96'(0));
        enq(32'd0, 32'd1, 32'd1, 32'h0, 32'h0, 32'h0);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        #1;
        check("err_set_wins", 96'(err_zero_dim), 96'(1));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Abort while running with two jobs queued
        b_next = 40;
        enq(32'd4, 32'd4, 32'd4, 32'h0, 32'h0, 32'h0);
        enq(32'd5, 32'd5, 32'd5, 32'h0, 32'h0, 32'h0);
        enq(32'd6, 32'd6, 32'd6, 32'h0, 32'h0, 32'h0);
        tick(); tick(); tick(); tick();
        s0 = n_start; d0 = n_done; jc0 = jobs_completed;
        abort = 1'b1;
        cmd_bus.cmd_valid = 1'b1;
        tick();
        abort = 1'b0;
        cmd_bus.cmd_valid = 1'b0;
        #1;
        check("abort_mm_rst", 96'(mm_rst), 96'(1));
        check("abort_grant_busy", 96'({host_grant, busy, cmd_bus.cmd_ready}), 96'(3'b101));
        tick();
        check("abort_mm_rst_pulse", 96'(mm_rst), 96'(0));
        repeat (60) tick();
        check("abort_no_done", 96'(n_done), 96'(d0));
        check("abort_no_start", 96'(n_start), 96'(s0));
        check("abort_jobs_completed", 96'(jobs_completed), 96'(jc0));
        check("abort_grant_stays", 96'(host_grant), 96'(1));

        // Reset asserted mid-RUN
        s0 = n_start;
        enq(32'd3, 32'd3, 32'd3, 32'h0, 32'h0, 32'h0);
        wait_start(s0 + 1, 20);
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        check("midrst_counts", {jobs_completed, last_cycles, mm_x_rows}, 96'(0));
        check("midrst_flags", 96'({mm_rst, host_grant, cmd_bus.cmd_ready, busy, job_done, mm_start, err_zero_dim}),
              96'(7'b1110000));
        tick(); tick();
        rst_n = 1'b1;
        #1;
        check("midrst_mm_rst_held", 96'(mm_rst), 96'(1));
        tick();
        check("midrst_mm_rst_low", 96'(mm_rst), 96'(0));

        // Randomized job stream against a queue-based reference
        clear_logs();
        rand_mode = 1'b1;
        s0 = n_start; d0 = n_done;
        nvalid = 0; any_zero = 1'b0;
        for (int j = 0; j < 30; j++) begin
            xr  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 9));
            yc  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 9));
            inr = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 9));
            if (xr == 0 || yc == 0 || inr == 0) begin
                any_zero = 1'b1;
            end else begin
                exp_dims.push_back({xr, yc, inr});
                nvalid++;
            end
            enq(xr, yc, inr, $urandom, $urandom, $urandom);
            repeat ($urandom_range(0, 8)) tick();
        end
        wait_done(d0 + nvalid, 2000);
        repeat (10) tick();
        check("rnd_grant", 96'({host_grant, busy}), 96'(2'b10));
        check("rnd_starts", 96'(n_start - s0), 96'(nvalid));
        check("rnd_jobs_completed", 96'(jobs_completed), 96'(nvalid));
        check("rnd_err", 96'(err_zero_dim), 96'(any_zero));
        for (int i = 0; i < nvalid; i++) begin
            if (i < start_log.size())
                check("rnd_dims", start_log[i], exp_dims[i]);
            if (i < done_lc.size() && i < b_log.size())
                check("rnd_last_cycles", 96'(done_lc[i]), 96'((b_log[i] == 0) ? 2 : b_log[i] + 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end
endmodule
